// File: rtl/uart_pkg.sv
// Shared UART definitions used by transmitter and receiver: FSM encodings,
// bit-timing constants and configuration field positions.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } uart_state_e;

   localparam int SampleCounterMax = 15;
   localparam int BaseDataWidth    = 5;

   localparam int ConfParityBit = 0;
   localparam int ConfStopLsb   = 1;
   localparam int ConfDataLsb   = 3;

   // Number of data bits selected by the data-width configuration field.
   function automatic int data_bits(input int sel);
      return BaseDataWidth + sel;
   endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional even parity
// and 1..4 stop bits, each bit timed by 16 ticks of an external baud enable.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int MAX_DATA_WIDTH       = 8,
   parameter int SAMPLE_COUNTER_WIDTH = 4,
   parameter int STOP_CONF_WIDTH      = 2,
   parameter int DATA_CONF_WIDTH      = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     baud_en_i,
   input  logic                                     tx_en_i,
   input  logic                                     tx_valid_i,
   input  logic [MAX_DATA_WIDTH-1:0]                tx_data_i,
   input  logic [STOP_CONF_WIDTH+DATA_CONF_WIDTH:0] tx_conf_i,
   output logic                                     tx_ready_o,
   output logic                                     tx_busy_o,
   output logic                                     tx_done_o,
   output logic                                     uart_tx_o
);

   localparam int ConfW   = 1 + STOP_CONF_WIDTH + DATA_CONF_WIDTH;
   localparam int BitCntW = (MAX_DATA_WIDTH > 2) ? $clog2(MAX_DATA_WIDTH) : 1;

   uart_state_e                     r_state;
   logic [MAX_DATA_WIDTH-1:0]       r_shift;
   logic [ConfW-1:0]                r_conf;
   logic                            r_parity;
   logic [SAMPLE_COUNTER_WIDTH-1:0] r_sample_cnt;
   logic [BitCntW-1:0]              r_bit_cnt;
   logic [STOP_CONF_WIDTH-1:0]      r_stop_cnt;
   logic                            r_busy;
   logic                            r_done;
   logic                            r_tx;

   logic                            w_ready;
   logic                            w_accept;
   logic                            w_active;
   logic                            w_bit_end;
   logic                            w_last_data;
   logic                            w_last_stop;
   logic [MAX_DATA_WIDTH-1:0]       w_masked;

   // Clearing the unused upper bits lets parity be a plain XOR of the register.
   function automatic logic [MAX_DATA_WIDTH-1:0] f_mask_data(
      input logic [MAX_DATA_WIDTH-1:0]  data,
      input logic [DATA_CONF_WIDTH-1:0] sel
   );
      logic [MAX_DATA_WIDTH-1:0] m;
      for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
         m[i] = data[i] & (i < data_bits(int'(sel)));
      end
      return m;
   endfunction

   always_comb begin
      w_ready     = (r_state == ST_IDLE) && tx_en_i && !rst_i;
      w_accept    = w_ready && tx_valid_i;
      w_active    = (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
      w_bit_end   = w_active && baud_en_i &&
                    (r_sample_cnt == SAMPLE_COUNTER_WIDTH'(SampleCounterMax));
      w_last_data = (int'(r_bit_cnt) ==
                     data_bits(int'(r_conf[ConfDataLsb +: DATA_CONF_WIDTH])) - 1);
      w_last_stop = (r_stop_cnt == r_conf[ConfStopLsb +: STOP_CONF_WIDTH]);
      w_masked    = f_mask_data(tx_data_i, tx_conf_i[ConfDataLsb +: DATA_CONF_WIDTH]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_conf       <= '0;
         r_parity     <= 1'b0;
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_tx         <= 1'b1;
      end else begin
         r_done <= 1'b0;

         // The line register reflects the current state and bit, one clk behind.
         case (r_state)
            ST_START:  r_tx <= 1'b0;
            ST_DATA:   r_tx <= r_shift[0];
            ST_PARITY: r_tx <= r_parity;
            default:   r_tx <= 1'b1;
         endcase

         if (w_active && baud_en_i) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state      <= ST_START;
                  r_shift      <= w_masked;
                  r_conf       <= tx_conf_i;
                  r_parity     <= ^w_masked;
                  r_sample_cnt <= '0;
                  r_bit_cnt    <= '0;
                  r_stop_cnt   <= '0;
                  r_busy       <= 1'b1;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (w_last_data) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_conf[ConfParityBit] ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  if (w_last_stop) begin
                     r_stop_cnt <= '0;
                     r_state    <= ST_DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready_o = w_ready;
   assign tx_busy_o  = r_busy;
   assign tx_done_o  = r_done;
   assign uart_tx_o  = r_tx;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: table of frames plus corner sequences, with a
// mid-bit line sampler checking against a queue of expected frames.
module tb_uart_tx_engine;

   logic       clk;
   logic       rst_i;
   logic       baud_en_i;
   logic       tx_en_i;
   logic       tx_valid_i;
   logic [7:0] tx_data_i;
   logic [4:0] tx_conf_i;
   logic       tx_ready_o;
   logic       tx_busy_o;
   logic       tx_done_o;
   logic       uart_tx_o;

   uart_tx_engine dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .baud_en_i  (baud_en_i),
      .tx_en_i    (tx_en_i),
      .tx_valid_i (tx_valid_i),
      .tx_data_i  (tx_data_i),
      .tx_conf_i  (tx_conf_i),
      .tx_ready_o (tx_ready_o),
      .tx_busy_o  (tx_busy_o),
      .tx_done_o  (tx_done_o),
      .uart_tx_o  (uart_tx_o)
   );

   typedef struct {
      logic [15:0] seq;    // line bits in send order, first bit at [nbits-1]
      int          nbits;
      int          ticks;
   } frame_t;

   typedef struct {
      logic [7:0]  data;
      logic [4:0]  conf;
      logic [15:0] seq;
      int          nbits;
      int          ticks;
   } vec_t;

   localparam int NV = 6;
   vec_t   vecs[NV];
   frame_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int frames_done = 0;
   int mon_ticks = 0;
   int mon_idx = 0;
   int baud_div = 4;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      int bcnt;
      bcnt = 0;
      baud_en_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bcnt >= baud_div - 1) begin
            bcnt = 0;
            baud_en_i = 1'b1;
         end else begin
            bcnt++;
            baud_en_i = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic frame_t model(input logic [7:0] d, input logic [4:0] c);
      frame_t f;
      int n;
      int s;
      logic par;
      n = 5 + int'(c[4:3]);
      s = 1 + int'(c[2:1]);
      par = 1'b0;
      f.seq = {15'd0, 1'b0};
      f.nbits = 1;
      for (int i = 0; i < n; i++) begin
         f.seq = {f.seq[14:0], d[i]};
         par = par ^ d[i];
         f.nbits++;
      end
      if (c[0]) begin
         f.seq = {f.seq[14:0], par};
         f.nbits++;
      end
      for (int i = 0; i < s; i++) begin
         f.seq = {f.seq[14:0], 1'b1};
         f.nbits++;
      end
      f.ticks = 16 * f.nbits;
      return f;
   endfunction

   // Monitor: counts baud ticks while busy, samples the line mid-bit.
   initial begin
      logic prev_done;
      logic active;
      frame_t f;
      prev_done = 1'b0;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            if (active && exp_q.size() > 0) exp_q.delete(0);
            active = 1'b0;
            mon_ticks = 0;
            mon_idx = 0;
            prev_done = 1'b0;
         end else begin
            if (prev_done) check("done_one_clk", 32'(tx_done_o), 32'd0);
            prev_done = tx_done_o;
            if (tx_busy_o) begin
               active = 1'b1;
               if (baud_en_i) begin
                  if (mon_ticks % 16 == 8) begin
                     if (exp_q.size() > 0 && mon_idx < exp_q[0].nbits)
                        check($sformatf("line_bit%0d", mon_idx), 32'(uart_tx_o),
                              32'(exp_q[0].seq[exp_q[0].nbits - 1 - mon_idx]));
                     mon_idx++;
                  end
                  mon_ticks++;
               end
            end
            if (tx_done_o) begin
               if (exp_q.size() == 0) begin
                  check("done_without_frame", 32'(exp_q.size()), 32'd1);
               end else begin
                  f = exp_q.pop_front();
                  check("frame_ticks", 32'(mon_ticks), 32'(f.ticks));
                  check("frame_bits", 32'(mon_idx), 32'(f.nbits));
                  check("busy_in_done", 32'(tx_busy_o), 32'd0);
               end
               frames_done++;
               active = 1'b0;
               mon_ticks = 0;
               mon_idx = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [4:0] c, input frame_t f);
      bit ok;
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      tx_valid_i = 1'b1;
      tx_data_i  = d;
      tx_conf_i  = c;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready_o) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      tx_valid_i = 1'b0;
      tx_data_i  = ~d;
      tx_conf_i  = ~c;
      check("accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_frames(input int target);
      for (int i = 0; i < 6000 && frames_done < target; i++) @(negedge clk);
      check("frames_completed", 32'(frames_done), 32'(target));
   endtask

   initial begin
      int expected;
      int rdy_hi;
      int bad;
      int saved;
      logic [7:0] rd;
      logic [4:0] rc;
      rst_i = 1'b1;
      tx_en_i = 1'b1;
      tx_valid_i = 1'b0;
      tx_data_i = 8'h00;
      tx_conf_i = 5'b00000;
      expected = 0;

      vecs[0] = '{8'hA5, 5'b11000, 16'b0101001011,    10, 160};
      vecs[1] = '{8'h1F, 5'b00011, 16'b011111111,     9,  144};
      vecs[2] = '{8'hFF, 5'b10111, 16'b0111111111111, 13, 208};
      vecs[3] = '{8'h3C, 5'b01001, 16'b000111101,     9,  144};
      vecs[4] = '{8'h80, 5'b00100, 16'b000000111,     9,  144};
      vecs[5] = '{8'hE1, 5'b00001, 16'b01000011,      8,  128};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_line", 32'(uart_tx_o), 32'd1);
      check("rst_busy", 32'(tx_busy_o), 32'd0);
      check("rst_done", 32'(tx_done_o), 32'd0);
      check("rst_ready", 32'(tx_ready_o), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(tx_ready_o), 32'd1);

      for (int v = 0; v < NV; v++) begin
         send(vecs[v].data, vecs[v].conf, '{vecs[v].seq, vecs[v].nbits, vecs[v].ticks});
         expected++;
         wait_frames(expected);
      end

      // Baud tick every clk, so a tick always coincides with the accept edge.
      baud_div = 1;
      send(vecs[0].data, vecs[0].conf, '{vecs[0].seq, vecs[0].nbits, vecs[0].ticks});
      expected++;
      wait_frames(expected);
      baud_div = 4;

      for (int r = 0; r < 4; r++) begin
         rd = 8'($urandom_range(0, 255));
         rc = 5'($urandom_range(0, 31));
         send(rd, rc, model(rd, rc));
         expected++;
         wait_frames(expected);
      end

      // Back-to-back frames with valid held high.
      exp_q.push_back('{16'b0001111001, 10, 160});
      exp_q.push_back('{16'b0001111001, 10, 160});
      @(posedge clk);
      #1;
      tx_valid_i = 1'b1;
      tx_data_i = 8'h3C;
      tx_conf_i = 5'b11000;
      for (int i = 0; i < 50 && !tx_busy_o; i++) @(negedge clk);
      rdy_hi = 0;
      for (int i = 0; i < 3000 && !tx_done_o; i++) begin
         @(negedge clk);
         if (tx_ready_o) rdy_hi++;
      end
      check("b2b_ready_low_in_frame", 32'(rdy_hi), 32'd0);
      @(negedge clk);
      check("b2b_ready_in_gap", 32'(tx_ready_o), 32'd1);
      check("b2b_busy_in_gap", 32'(tx_busy_o), 32'd0);
      @(negedge clk);
      check("b2b_busy_after_gap", 32'(tx_busy_o), 32'd1);
      check("b2b_ready_second", 32'(tx_ready_o), 32'd0);
      @(posedge clk);
      #1;
      tx_valid_i = 1'b0;
      expected += 2;
      wait_frames(expected);

      // Reset during data bit 3 aborts the frame.
      send(8'h5A, 5'b11000, model(8'h5A, 5'b11000));
      for (int i = 0; i < 3000 && mon_ticks < 16 * 4 + 4; i++) @(negedge clk);
      check("reached_bit3", 32'(mon_ticks >= 68), 32'd1);
      saved = frames_done;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("abort_line", 32'(uart_tx_o), 32'd1);
      check("abort_busy", 32'(tx_busy_o), 32'd0);
      check("abort_done", 32'(tx_done_o), 32'd0);
      repeat (100) @(negedge clk);
      check("abort_no_done", 32'(frames_done), 32'(saved));
      send(vecs[0].data, vecs[0].conf, '{vecs[0].seq, vecs[0].nbits, vecs[0].ticks});
      expected++;
      wait_frames(expected);

      // Disable mid-frame: frame completes, nothing further accepted.
      send(8'hC3, 5'b11010, model(8'hC3, 5'b11010));
      repeat (60) @(posedge clk);
      #1;
      tx_en_i = 1'b0;
      expected++;
      wait_frames(expected);
      @(posedge clk);
      #1;
      tx_valid_i = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_ready_o || tx_busy_o || !uart_tx_o) bad++;
      end
      check("disabled_idle", 32'(bad), 32'd0);
      tx_valid_i = 1'b0;
      tx_en_i = 1'b1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
